// File: rtl/instruction_queue_if.sv
// Fetch/dispatch-side handshake bundle for the instruction queue.
// The master side is fetch plus dispatch; the slave side is the queue itself.
interface instruction_queue_if #(
  parameter int DEPTH = 8,
  parameter int IW    = 32,
  parameter int AW    = 32
);
  localparam int CW = $clog2(DEPTH + 1);

  logic          flush;
  logic          enq_valid;
  logic [IW-1:0] enq_instr;
  logic [AW-1:0] enq_pc;
  logic          enq_ready;
  logic [1:0]    deq_valid;
  logic [IW-1:0] deq_instr0;
  logic [AW-1:0] deq_pc0;
  logic [IW-1:0] deq_instr1;
  logic [AW-1:0] deq_pc1;
  logic [1:0]    deq_count;
  logic [CW-1:0] count;

  modport master (
    output flush, enq_valid, enq_instr, enq_pc, deq_count,
    input  enq_ready, deq_valid, deq_instr0, deq_pc0, deq_instr1, deq_pc1, count
  );

  modport slave (
    input  flush, enq_valid, enq_instr, enq_pc, deq_count,
    output enq_ready, deq_valid, deq_instr0, deq_pc0, deq_instr1, deq_pc1, count
  );
endinterface

// File: rtl/instruction_queue.sv
// Circular instruction FIFO: one push per cycle from fetch, two oldest entries
// shown to dispatch, which may pop 0..2 per cycle. Flush empties it in one edge.
module instruction_queue #(
  parameter int DEPTH = 8,
  parameter int IW    = 32,
  parameter int AW    = 32
) (
  input logic                clk_in,
  input logic                rst_in,
  instruction_queue_if.slave q
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [IW-1:0] instr_mem [DEPTH];
  logic [AW-1:0] pc_mem    [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] cnt;
  logic [1:0]    req;
  logic [1:0]    n;
  logic          push;

  // A request of 3 means 2, and any pop is clipped to the current occupancy.
  always_comb begin
    req  = (q.deq_count == 2'd3) ? 2'd2 : q.deq_count;
    n    = (CW'(req) > cnt) ? cnt[1:0] : req;
    push = q.enq_valid && q.enq_ready && !q.flush;
  end

  assign q.enq_ready  = (cnt < FULL);
  assign q.deq_valid  = {(cnt >= CW'(2)), (cnt >= CW'(1))};
  assign q.deq_instr0 = instr_mem[head];
  assign q.deq_pc0    = pc_mem[head];
  assign q.deq_instr1 = instr_mem[head + PW'(1)];
  assign q.deq_pc1    = pc_mem[head + PW'(1)];
  assign q.count      = cnt;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        instr_mem[i] <= '0;
        pc_mem[i]    <= '0;
      end
    end else if (q.flush) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else begin
      if (push) begin
        instr_mem[tail] <= q.enq_instr;
        pc_mem[tail]    <= q.enq_pc;
        tail            <= tail + PW'(1);
      end
      head <= head + PW'(n);
      cnt  <= cnt + CW'(push) - CW'(n);
    end
  end
endmodule
